// File: rtl/sd_buf_pkg.sv
// sd_buf_pkg: shared sizes, word tag positions and writer FSM encoding for the SD block buffer.
package sd_buf_pkg;
    localparam int BLOCK_BYTES    = 512;
    localparam int NUM_SLOTS      = 4;
    localparam int WORDS_PER_SLOT = BLOCK_BYTES / 4;
    localparam int TAG_FIRST      = 32;
    localparam int TAG_LAST       = 33;
    localparam int TAG_SLOT_LO    = 34;
    localparam int TAG_SLOT_HI    = 35;
    typedef enum logic [1:0] {IDLE, FILL, WAIT_CRC} wr_state_e;
endpackage

// File: rtl/sd_slot_flags.sv
// sd_slot_flags: per-slot full/CRC-error flags; a commit overrides a release of the same slot.
module sd_slot_flags #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 commit,
    input  logic [$clog2(N)-1:0] commit_slot,
    input  logic                 commit_err,
    input  logic [N-1:0]         rel,
    output logic [N-1:0]         full,
    output logic [N-1:0]         crc_err
);
    logic [N-1:0] full_q, full_d, err_q, err_d;

    always_comb begin
        full_d = full_q & ~rel;
        err_d  = err_q & ~rel;
        if (commit) begin
            full_d[commit_slot] = 1'b1;
            err_d[commit_slot]  = commit_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= '0;
            err_q  <= '0;
        end else begin
            full_q <= full_d;
            err_q  <= err_d;
        end
    end

    assign full    = full_q;
    assign crc_err = err_q;
endmodule

// File: rtl/sd_rx_block_writer.sv
// sd_rx_block_writer: packs received SD bytes into tagged 36-bit words and writes one
// block per RAM slot, committing each slot on the block's CRC verdict.
module sd_rx_block_writer #(
    parameter int BLOCK_BYTES = sd_buf_pkg::BLOCK_BYTES,
    parameter int NUM_SLOTS   = sd_buf_pkg::NUM_SLOTS,
    parameter int ADDR_W      = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    input  logic                 crc_ok,
    input  logic                 crc_err,
    input  logic                 blk_abort,
    input  logic                 err_clr,
    input  logic [NUM_SLOTS-1:0] slot_release,
    output logic [ADDR_W-1:0]    bram_addr,
    output logic [35:0]          bram_din,
    output logic                 bram_wr,
    output logic [NUM_SLOTS-1:0] slot_full,
    output logic [NUM_SLOTS-1:0] slot_crc_err,
    output logic [1:0]           wr_slot,
    output logic                 blk_done,
    output logic                 overflow_err
);
    import sd_buf_pkg::*;

    localparam int CW  = $clog2(BLOCK_BYTES);
    localparam int WPS = BLOCK_BYTES / 4;

    wr_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        slot_q, slot_d;
    logic [23:0]       pack_q, pack_d;
    logic              wr_q, wr_d, done_q, done_d, ovf_q, ovf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [35:0]       din_q, din_d;
    logic              commit;
    logic [CW-3:0]     word_idx;

    assign word_idx = cnt_q[CW-1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        pack_d  = pack_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = 1'b0;
        commit  = 1'b0;
        ovf_d   = (state_q == WAIT_CRC && byte_valid) || (ovf_q && !err_clr);
        case (state_q)
            IDLE: state_d = slot_full[slot_q] ? IDLE : FILL;
            FILL: begin
                if (blk_abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (byte_valid) begin
                    cnt_d = (cnt_q == CW'(BLOCK_BYTES - 1)) ? '0 : cnt_q + 1'b1;
                    state_d = (cnt_q == CW'(BLOCK_BYTES - 1)) ? WAIT_CRC : FILL;
                    if (cnt_q[1:0] == 2'd3) begin
                        wr_d                           = 1'b1;
                        addr_d                         = ADDR_W'(slot_q * WPS) + ADDR_W'(word_idx);
                        din_d[31:0]                    = {byte_in, pack_q};
                        din_d[TAG_FIRST]               = (word_idx == '0);
                        din_d[TAG_LAST]                = (word_idx == (CW-2)'(WPS - 1));
                        din_d[TAG_SLOT_HI:TAG_SLOT_LO] = slot_q;
                    end else begin
                        pack_d[8*cnt_q[1:0] +: 8] = byte_in;
                    end
                end
            end
            WAIT_CRC: begin
                // abort outranks a CRC verdict arriving in the same cycle
                if (blk_abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (crc_ok || crc_err) begin
                    commit  = 1'b1;
                    done_d  = 1'b1;
                    slot_d  = 2'((32'(slot_q) + 1) % NUM_SLOTS);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            pack_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            pack_q  <= pack_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    sd_slot_flags #(.N(NUM_SLOTS)) u_flags (
        .clk        (clk),
        .reset      (reset),
        .commit     (commit),
        .commit_slot(slot_q),
        .commit_err (crc_err),
        .rel        (slot_release),
        .full       (slot_full),
        .crc_err    (slot_crc_err)
    );

    assign byte_ready   = (state_q == FILL);
    assign bram_wr      = wr_q;
    assign bram_addr    = addr_q;
    assign bram_din     = din_q;
    assign blk_done     = done_q;
    assign overflow_err = ovf_q;
    assign wr_slot      = slot_q;
endmodule

// File: tb/tb_sd_rx_block_writer.sv
// tb_sd_rx_block_writer: random-paced block traffic; expected RAM words are queued as bytes
// are accepted and a monitor pops them on every write.
module tb_sd_rx_block_writer;
    logic        clk = 1'b0, reset = 1'b1;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0, crc_ok = 1'b0, crc_err = 1'b0, blk_abort = 1'b0, err_clr = 1'b0;
    logic [3:0]  slot_release = '0;
    logic        byte_ready, bram_wr, blk_done, overflow_err;
    logic [8:0]  bram_addr;
    logic [35:0] bram_din;
    logic [3:0]  slot_full, slot_crc_err;
    logic [1:0]  wr_slot;

    sd_rx_block_writer dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .crc_ok(crc_ok), .crc_err(crc_err), .blk_abort(blk_abort), .err_clr(err_clr),
        .slot_release(slot_release), .bram_addr(bram_addr), .bram_din(bram_din), .bram_wr(bram_wr),
        .slot_full(slot_full), .slot_crc_err(slot_crc_err), .wr_slot(wr_slot), .blk_done(blk_done),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [8:0] a; logic [35:0] d;} wr_t;
    wr_t         exp_q[$];
    int          n_chk = 0, n_pass = 0;
    int          m_slot = 0;
    logic [3:0]  m_full = '0, m_err = '0;
    logic [7:0]  blk[512];
    logic [35:0] cap0 = '0, cap127 = '0;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && bram_wr) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: got addr %h din %h, required no write", bram_addr, bram_din);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 36'(bram_addr), 36'(e.a));
                chk("wr_din", bram_din, e.d);
            end
            if (bram_addr == 9'd0) cap0 = bram_din;
            if (bram_addr == 9'd127) cap127 = bram_din;
        end
    end

    task automatic fill_pattern();
        for (int i = 0; i < 512; i++) blk[i] = 8'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 512; i++) blk[i] = 8'($urandom);
    endtask

    // a whole word of the block is expected once its fourth byte is accepted
    task automatic send_bytes(input int n);
        int i = 0, cyc = 0;
        while (i < n) begin
            @(negedge clk);
            cyc++;
            if (cyc > 4000) begin
                n_chk++;
                $display("FAIL send_timeout: got %0d bytes accepted, required %0d", i, n);
                break;
            end
            byte_valid = ($urandom_range(0, 3) != 0);
            byte_in = blk[i];
            if (byte_valid && byte_ready) begin
                if (i % 4 == 3) begin
                    int w = i / 4;
                    exp_q.push_back({9'(m_slot * 128 + w), 2'(m_slot), w == 127, w == 0,
                                     blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]});
                end
                i++;
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_crc(input bit ok, input bit err);
        crc_ok = ok;
        crc_err = err;
        @(negedge clk);
        crc_ok = 1'b0;
        crc_err = 1'b0;
        m_full[m_slot] = 1'b1;
        m_err[m_slot] = err;
        m_slot = (m_slot + 1) % 4;
        chk("blk_done_pulse", 36'(blk_done), 36'(1));
        chk("slot_full", 36'(slot_full), 36'(m_full));
        chk("slot_crc_err", 36'(slot_crc_err), 36'(m_err));
        chk("wr_slot", 36'(wr_slot), 36'(m_slot));
        @(negedge clk);
        chk("blk_done_end", 36'(blk_done), 36'(0));
    endtask

    task automatic release_slots(input logic [3:0] r);
        slot_release = r;
        @(negedge clk);
        slot_release = '0;
        m_full = m_full & ~r;
        m_err = m_err & ~r;
        chk("release_full", 36'(slot_full), 36'(m_full));
        chk("release_err", 36'(slot_crc_err), 36'(m_err));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy;
        repeat (3) @(negedge clk);
        chk("rst_byte_ready", 36'(byte_ready), 36'(0));
        chk("rst_bram_wr", 36'(bram_wr), 36'(0));
        chk("rst_slot_full", 36'(slot_full), 36'(0));
        chk("rst_wr_slot", 36'(wr_slot), 36'(0));
        chk("rst_overflow", 36'(overflow_err), 36'(0));
        reset = 1'b0;
        crc_err = 1'b1;
        @(negedge clk);
        crc_err = 1'b0;
        @(negedge clk);
        chk("crc_idle_ignored", 36'(slot_full), 36'(0));
        chk("crc_idle_no_done", 36'(blk_done), 36'(0));

        fill_pattern();
        send_bytes(512);
        do_crc(1'b1, 1'b0);
        chk("word0", cap0, 36'h1_0302_0100);
        chk("word127", cap127, 36'h2_FFFE_FDFC);

        for (int b = 1; b < 4; b++) begin
            fill_random();
            send_bytes(512);
            do_crc(b != 2, b == 2);
        end
        rdy = 0;
        byte_valid = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (byte_ready) rdy++;
        end
        byte_valid = 1'b0;
        chk("all_full_backpressure", 36'(rdy), 36'(0));

        release_slots(4'b0001);
        chk("idle_not_ready", 36'(byte_ready), 36'(0));
        @(negedge clk);
        chk("ready_after_release", 36'(byte_ready), 36'(1));
        fill_random();
        send_bytes(512);
        do_crc(1'b1, 1'b0);
        release_slots(4'b1111);

        fill_random();
        send_bytes(10);
        byte_valid = 1'b1;
        byte_in = 8'hAA;
        blk_abort = 1'b1;
        @(negedge clk);
        blk_abort = 1'b0;
        byte_valid = 1'b0;
        chk("abort_idle", 36'(byte_ready), 36'(0));
        chk("abort_wr_slot", 36'(wr_slot), 36'(m_slot));
        fill_random();
        send_bytes(512);
        blk_abort = 1'b1;
        crc_ok = 1'b1;
        @(negedge clk);
        blk_abort = 1'b0;
        crc_ok = 1'b0;
        chk("abort_over_crc_full", 36'(slot_full), 36'(0));
        chk("abort_over_crc_done", 36'(blk_done), 36'(0));
        fill_random();
        send_bytes(512);
        do_crc(1'b1, 1'b0);

        fill_random();
        send_bytes(512);
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        chk("overflow_set", 36'(overflow_err), 36'(1));
        do_crc(1'b1, 1'b0);
        chk("overflow_sticky", 36'(overflow_err), 36'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("overflow_cleared", 36'(overflow_err), 36'(0));
        fill_random();
        send_bytes(512);
        byte_valid = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        err_clr = 1'b0;
        chk("overflow_set_wins", 36'(overflow_err), 36'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("overflow_clr2", 36'(overflow_err), 36'(0));
        do_crc(1'b1, 1'b1);

        fill_random();
        send_bytes(52);
        chk("pre_reset_wr", 36'(bram_wr), 36'(1));
        #2 reset = 1'b1;
        #1;
        chk("async_bram_wr", 36'(bram_wr), 36'(0));
        chk("async_bram_addr", 36'(bram_addr), 36'(0));
        chk("async_bram_din", bram_din, 36'(0));
        chk("async_slot_full", 36'(slot_full), 36'(0));
        chk("async_slot_err", 36'(slot_crc_err), 36'(0));
        chk("async_byte_ready", 36'(byte_ready), 36'(0));
        chk("async_overflow", 36'(overflow_err), 36'(0));
        exp_q.delete();
        m_full = '0;
        m_err = '0;
        m_slot = 0;
        #4 reset = 1'b0;
        fill_pattern();
        send_bytes(512);
        do_crc(1'b1, 1'b0);
        chk("post_reset_word0", cap0, 36'h1_0302_0100);
        chk("queue_empty", 36'(exp_q.size()), 36'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sd_rx_block_writer.md
Name: sd_rx_block_writer

Overview:
- Downstream of the SD host data-line receiver; upstream of the 512x36 dual-port block RAM.
- Packs the received SD data byte stream into 36-bit words and writes them into the RAM through port A.
- Treats the RAM as 4 slots of 128 words, each holding one 512-byte SD block.
- Maintains per-slot full/CRC-error flags; the consumer on port B frees slots with release pulses.

Parameters:
- BLOCK_BYTES, 512, bytes per SD block; must be a multiple of 4.
- NUM_SLOTS, 4, RAM slots; BLOCK_BYTES/4*NUM_SLOTS must be 512.
- ADDR_W, 9, RAM address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- byte_in  in  8  received data byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  writer accepts byte; transfer on byte_valid & byte_ready
- crc_ok  in  1  one-cycle pulse: block CRC passed
- crc_err  in  1  one-cycle pulse: block CRC failed
- blk_abort  in  1  discard the partial block in progress
- err_clr  in  1  clears overflow_err
- slot_release  in  NUM_SLOTS  one-hot pulse from consumer: free slot i
- bram_addr  out  ADDR_W  port A address
- bram_din  out  36  port A write data
- bram_wr  out  1  port A write strobe
- slot_full  out  NUM_SLOTS  slot i holds a complete block
- slot_crc_err  out  NUM_SLOTS  CRC status of slot i; valid while slot_full[i]
- wr_slot  out  2  slot currently being filled or waited on
- blk_done  out  1  one-cycle pulse when a slot is committed
- overflow_err  out  1  sticky: byte_valid seen while not ready in WAIT_CRC

Behaviour:
- Reset: all outputs 0. State IDLE; slot pointer 0; byte counter 0; pack register 0.
- FSM state IDLE:
  - if slot_full[wr_slot]=0, go to FILL next cycle; otherwise hold.
  - byte_ready=0.
- FSM state FILL:
  - byte_ready=1.
  - Each accepted byte goes into lane byte_cnt[1:0]: the first byte of a word occupies bits 7:0, the fourth occupies bits 31:24.
  - On the 4th byte of a word, the next cycle drives bram_wr=1 with:
    - bram_addr = wr_slot*128 + word index (wraps within the slot only)
    - bram_din[31:0] = packed bytes
    - bram_din[32] = first word of block
    - bram_din[33] = last word of block
    - bram_din[35:34] = wr_slot
  - Write latency is exactly 1 cycle after the accepting edge. Back-to-back bytes give one write every 4 cycles.
  - After the 512th byte is accepted, go to WAIT_CRC. That byte's word write still occurs in the following cycle.
- FSM state WAIT_CRC:
  - byte_ready=0.
  - On crc_ok or crc_err:
    - set slot_full[wr_slot] and set slot_crc_err[wr_slot]=crc_err.
    - pulse blk_done, increment wr_slot modulo NUM_SLOTS, go to IDLE.
  - crc_ok and crc_err in the same cycle: treated as an error.
  - CRC pulses in IDLE or FILL are ignored.
- blk_abort:
  - In FILL or WAIT_CRC, go to IDLE next cycle.
  - Clear the byte counter; do not advance wr_slot; do not set any flag.
  - Words already written stay in RAM and will be overwritten.
  - A byte accepted in the abort cycle is discarded, and no write is issued for it.
  - In WAIT_CRC, abort has priority over a simultaneous CRC pulse.
- slot_release[i]:
  - clears slot_full[i] and slot_crc_err[i] next cycle; ignored if the slot is not full.
  - Same-cycle commit and release of the same slot: commit wins, because that slot was empty before the commit.
- All 4 slots full: FSM waits in IDLE, byte_ready=0, and backpressure reaches the SD receiver.
- overflow_err:
  - set when byte_valid=1 in WAIT_CRC.
  - cleared by err_clr; set has priority when both occur in the same cycle.
- slot_full, slot_crc_err and wr_slot are registered outputs; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package sd_buf_pkg holds:
  - BLOCK_BYTES, WORDS_PER_SLOT (128), NUM_SLOTS
  - bit positions of the word tag fields (FIRST=32, LAST=33, SLOT=35:34)
  - the FSM state encoding (IDLE, FILL, WAIT_CRC)
- One natural sub-module: sd_slot_flags.
  - Holds the slot_full/slot_crc_err register array with its commit/release/priority logic.
  - The consumer-side reader stage reuses it.

Test Plan:
- Reset, then 512 bytes 0x00..0xFF repeating, then crc_ok:
  - 128 writes to addresses 0..127; word 0 = 36'h1_0302_0100 (first=1); word 127 = 36'h2_FFFE_FDFC.
  - slot_full=4'b0001, blk_done pulses once, wr_slot=1.
- Four blocks; block 3 ends with crc_err, no releases:
  - slot_full=4'hF, slot_crc_err=4'b0100.
  - A fifth block sees byte_ready=0 indefinitely.
- Continuing from that state, slot_release=4'b0001:
  - one cycle later slot_full=4'hE; wr_slot wraps to 0; byte_ready=1 the cycle after IDLE exits; writes start at address 0.
- blk_abort after 10 bytes of slot 1, then a full block with crc_ok:
  - only slot 1 is set; its word 0 holds the new data with the first flag set.
- byte_valid held high in WAIT_CRC:
  - overflow_err=1 and stays set through crc_ok; err_clr clears it; a simultaneous set and err_clr leaves it 1.
- Assert reset asynchronously mid-FILL (not on a clk edge):
  - all outputs 0 immediately, including bram_wr.
  - after release, the next block writes from address 0.
